// File: rtl/flow_pkg.sv
// Shared definitions for the flow arbiter: mode encoding and index-width helper.
package flow_pkg;

    localparam int unsigned STEERED     = 0;
    localparam int unsigned ROUND_ROBIN = 1;

    // Index width for n channels, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-pick: first asserted request at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/flow_arbiter_n.sv
// N-input arbiter into a single registered output bundle, round-robin or sel-steered.
// The payload and winner index share one register and transfer jointly downstream.
module flow_arbiter_n
    import flow_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned MODE = 1,
    localparam int unsigned IW  = idx_width(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0][W:0]   in_data,
    output logic [N-1:0]        in_back_stop,
    input  logic [IW:0]         sel,
    output logic                sel_back_stop,
    output logic [W:0]          out_data,
    input  logic                down_stop,
    output logic [IW:0]         chose,
    input  logic                chose_down_stop,
    output logic                sel_err
);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          sel_err_q, sel_err_d;

    logic [N-1:0]  req;
    logic          rr_valid;
    logic [IW-1:0] rr_idx;
    logic          sel_valid, sel_in_range, target_valid;
    logic [IW-1:0] sel_idx, winner;
    logic [W-1:0]  win_data;
    logic          drain, free, accept, err_consume;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    assign sel_valid    = sel[IW];
    assign sel_idx      = sel[IW-1:0];
    assign sel_in_range = 32'(sel_idx) < N;

    // Joint transfer: both downstream consumers must be ready together.
    assign drain = valid_q & ~down_stop & ~chose_down_stop;
    // Gating with rst_n keeps every stop high while reset is asserted.
    assign free  = rst_n & (~valid_q | drain);

    always_comb begin
        req          = '0;
        target_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            req[k] = in_data[k][W];
            if (sel_idx == IW'(k)) begin
                target_valid = in_data[k][W];
            end
        end
    end

    always_comb begin
        accept      = 1'b0;
        err_consume = 1'b0;
        winner      = '0;
        if (MODE == ROUND_ROBIN) begin
            winner = rr_idx;
            accept = free & rr_valid;
        end else begin
            winner      = sel_idx;
            accept      = free & sel_valid & sel_in_range & target_valid;
            err_consume = free & sel_valid & ~sel_in_range;
        end
    end

    always_comb begin
        win_data     = '0;
        in_back_stop = '1;
        for (int unsigned k = 0; k < N; k++) begin
            if (winner == IW'(k)) begin
                win_data = in_data[k][W-1:0];
            end
            if (accept && winner == IW'(k)) begin
                in_back_stop[k] = 1'b0;
            end
        end
        sel_back_stop = (MODE == ROUND_ROBIN) ? 1'b1 : ~(accept | err_consume);
    end

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        sel_err_d = sel_err_q | err_consume;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d = 1'b1;
            data_d  = win_data;
            idx_d   = winner;
            if (MODE == ROUND_ROBIN) begin
                ptr_d = (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign out_data = {valid_q, data_q};
    assign chose    = {valid_q, idx_q};
    assign sel_err  = sel_err_q;

endmodule
